// File: rtl/fhew_pkg.sv
// Shared constants, types and helpers for the signed digit decomposition stage
// that sits between the INTT readout and the NTT input of the accumulator loop.
package fhew_pkg;

    localparam int DATA_W      = 27;
    localparam int Q           = 132120577;      // 2^27 - 2^21 + 1
    localparam int LANES       = 4;
    localparam int RING_DEPTH  = 10;
    localparam int BG_LOG      = 9;
    localparam int NUM_DIGITS  = 3;

    localparam int ADDR_W      = RING_DEPTH - $clog2(LANES);
    localparam int FRAME_BEATS = 1 << ADDR_W;    // RING_SIZE / LANES
    localparam int ROUND_BITS  = (DATA_W > BG_LOG * NUM_DIGITS) ?
                                 DATA_W - BG_LOG * NUM_DIGITS : 0;

    localparam int IN_W        = LANES * DATA_W;
    localparam int OUT_W       = NUM_DIGITS * LANES * DATA_W;

    typedef logic        [DATA_W-1:0] coeff_t;
    typedef logic signed [DATA_W:0]   scoeff_t;
    typedef logic        [ADDR_W-1:0] addr_t;
    typedef logic        [ADDR_W:0]   cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam coeff_t  Q_HALF    = coeff_t'((Q - 1) / 2);
    localparam scoeff_t Q_S       = scoeff_t'(Q);
    localparam cnt_t    FRAME_CNT = cnt_t'(FRAME_BEATS);
    localparam addr_t   LAST_ADDR = addr_t'(FRAME_BEATS - 1);

    // Map x in [0,Q) to the centred range (-Q/2, Q/2].
    function automatic scoeff_t centre(input coeff_t x);
        scoeff_t xs;
        xs = $signed({1'b0, x});
        return (x > Q_HALF) ? xs - Q_S : xs;
    endfunction

    // Map a small signed digit back into [0,Q).
    function automatic coeff_t to_mod_q(input scoeff_t d);
        return d[DATA_W] ? coeff_t'(d + Q_S) : coeff_t'(d);
    endfunction

endpackage

// File: rtl/signed_digit_decompose_digit_extract_stage.sv
// One base-2^BG_LOG step of the signed decomposition: peels the centred low
// digit off a signed residual and returns the exactly shifted remainder.
module digit_extract_stage
    import fhew_pkg::*;
(
    input  scoeff_t residual,
    output scoeff_t digit,
    output scoeff_t next_residual
);

    scoeff_t diff;

    // Centred digit in [-B/2, B/2) and the residual with that digit removed
    always_comb begin
        // NOTE: blocking assignments here; diff must hold its new value before
        // next_residual reads it in the same evaluation.
        digit         = scoeff_t'({{(DATA_W + 1 - BG_LOG){residual[BG_LOG-1]}},
                                   residual[BG_LOG-1:0]});
        diff          = residual - digit;
        next_residual = diff >>> BG_LOG;
    end

endmodule

// File: rtl/signed_digit_decompose.sv
// Signed digit decomposition pipeline for one ring polynomial per frame.
// Each accepted beat of LANES coefficients is recentred, split into
// NUM_DIGITS signed base-2^BG_LOG digits and emitted, mapped back to [0,Q),
// NUM_DIGITS+1 cycles later together with its beat address.
// Build option: DECOMP_ROUND_EN adds round-half-up of the centred value to a
// multiple of 2^ROUND_BITS in stage 0; digit 0 then starts at bit ROUND_BITS.
module signed_digit_decompose
    import fhew_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_t  state;
    state_t  state_nx;
    cnt_t    in_cnt;
    addr_t   out_cnt;
    logic    en;
    logic    in_fire;
    logic    out_fire;

    // Pipeline: stage 0 holds the centred value, stages 1..NUM_DIGITS-1 each
    // retire one digit, and the output stage holds the digits mapped to [0,Q).
    logic [NUM_DIGITS:0] vld_q;
    scoeff_t res_q [NUM_DIGITS][LANES];
    scoeff_t dig_q [NUM_DIGITS][NUM_DIGITS-1][LANES];
    coeff_t  out_q [NUM_DIGITS][LANES];

    scoeff_t ext_dig [NUM_DIGITS-1][LANES];
    scoeff_t ext_res [NUM_DIGITS-1][LANES];
    scoeff_t cen     [LANES];

    assign out_valid = vld_q[NUM_DIGITS];
    assign en        = !out_valid || out_ready;
    assign in_ready  = (state == ST_RUN) && (in_cnt < FRAME_CNT) && en;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_last  = out_valid && (out_cnt == LAST_ADDR);
    assign out_addr  = out_cnt;

    // Frame state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and frame status outputs
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // can leave it unassigned and infer a latch.
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (in_cnt == FRAME_CNT) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (out_fire && out_last) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Input and output beat counters; a new frame clears both
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (in_fire) begin
                in_cnt <= in_cnt + cnt_t'(1);
            end
            if (out_fire) begin
                out_cnt <= out_cnt + addr_t'(1);
            end
        end
    end

    // Stage-0 arithmetic: recentre each lane (and optionally round)
`ifdef DECOMP_ROUND_EN
    localparam scoeff_t RND_HALF = scoeff_t'((1 << ROUND_BITS) >> 1);
`endif
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            cen[l] = centre(in_data[l*DATA_W +: DATA_W]);
`ifdef DECOMP_ROUND_EN
            cen[l] = (cen[l] + RND_HALF) >>> ROUND_BITS;
`endif
        end
    end

    // Digit extractors between consecutive residual stages
    for (genvar s = 0; s < NUM_DIGITS - 1; s++) begin : g_stage
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            digit_extract_stage u_extract (
                .residual      (res_q[s][l]),
                .digit         (ext_dig[s][l]),
                .next_residual (ext_res[s][l])
            );
        end
    end

    // Pipeline registers: all stages advance together whenever en is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the datapath flops are reset as well so that every output,
            // including out_data, reads zero while reset is held.
            vld_q <= '0;
            for (int s = 0; s < NUM_DIGITS; s++) begin
                for (int l = 0; l < LANES; l++) begin
                    res_q[s][l] <= '0;
                    out_q[s][l] <= '0;
                    for (int j = 0; j < NUM_DIGITS - 1; j++) begin
                        dig_q[s][j][l] <= '0;
                    end
                end
            end
        end else if (en) begin
            vld_q <= {vld_q[NUM_DIGITS-1:0], in_fire};
            for (int l = 0; l < LANES; l++) begin
                res_q[0][l] <= cen[l];
                for (int j = 0; j < NUM_DIGITS - 1; j++) begin
                    dig_q[0][j][l] <= '0;
                end
                for (int s = 1; s < NUM_DIGITS; s++) begin
                    res_q[s][l] <= ext_res[s-1][l];
                    for (int j = 0; j < NUM_DIGITS - 1; j++) begin
                        dig_q[s][j][l] <= (j == s - 1) ? ext_dig[s-1][l]
                                                       : dig_q[s-1][j][l];
                    end
                end
                for (int j = 0; j < NUM_DIGITS - 1; j++) begin
                    out_q[j][l] <= to_mod_q(dig_q[NUM_DIGITS-1][j][l]);
                end
                out_q[NUM_DIGITS-1][l] <= to_mod_q(res_q[NUM_DIGITS-1][l]);
            end
        end
    end

    // Pack digit k of lane l at slice (k*LANES + l)
    always_comb begin
        out_data = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            for (int l = 0; l < LANES; l++) begin
                out_data[(k*LANES + l)*DATA_W +: DATA_W] = out_q[k][l];
            end
        end
    end

    // Coefficients entering the pipeline must already be reduced mod Q
    always_ff @(posedge clk) begin
        if (!reset && in_fire) begin
            for (int l = 0; l < LANES; l++) begin
                assert (in_data[l*DATA_W +: DATA_W] < coeff_t'(Q));
            end
        end
    end

endmodule

// File: doc/signed_digit_decompose.md
Name: signed_digit_decompose

Overview:
- Pipelined stage between the INTT output BRAM readout and the NTT input write port of the accumulator loop.
- Takes one ring polynomial (RING_SIZE coefficients mod Q), LANES coefficients per beat.
- Recentres each coefficient to (-Q/2, Q/2] and splits it into NUM_DIGITS signed base-2^BG_LOG digits.
- Emits all digits of each beat in parallel, mapped back to [0,Q), with a write address, for the NTT banks.

Parameters:
- DATA_W, 27, coefficient width.
- Q, 132120577, modulus (2^27-2^21+1).
- LANES, 4, coefficients per beat.
- RING_DEPTH, 10, log2 RING_SIZE.
- BG_LOG, 9, log2 digit base B.
- NUM_DIGITS, 3, digits per coefficient.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse: begin frame
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when valid&ready
- in_data  in  LANES*DATA_W  coefficients, lane 0 in LSBs
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  NUM_DIGITS*LANES*DATA_W  digit k of lane l at slice (k*LANES+l)*DATA_W
- out_addr  out  RING_DEPTH-log2(LANES)  beat index within frame
- out_last  out  1  final beat of frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, pipeline valid bits 0. Reset mid-frame aborts the frame; no done pulse.
- FRAME_BEATS = RING_SIZE/LANES (256 at defaults).
- States:
  - IDLE: on start go to RUN and clear in_cnt/out_cnt.
  - RUN: accept inputs until in_cnt==FRAME_BEATS, then go to DRAIN.
  - DRAIN: when the last beat is accepted downstream, go to DONE.
  - DONE: pulse done for one cycle, return to IDLE.
- start outside IDLE is ignored. busy=1 in RUN/DRAIN.
- in_ready = (state==RUN) && in_cnt<FRAME_BEATS && en.
- Input beats presented while in_ready=0 are not consumed.
- Pipeline: NUM_DIGITS+1 register stages. en = !out_valid || out_ready; all stages advance together on en. Stalls hold data unchanged.
- Latency: an accepted beat appears on out_data NUM_DIGITS+1 cycles later with no stall. Throughput is 1 beat/cycle.
- Stage 0 (centre): if x > (Q-1)/2 then v = x-Q, else v = x. Signed, DATA_W+1 bits. An input x >= Q is undefined; assert in simulation.
- Stage k, k < NUM_DIGITS-1:
  - r = v mod B in [0,B); if r >= B/2 then r -= B.
  - d_k = r; v = (v-r) >> BG_LOG (exact arithmetic shift).
- Last stage: d_{NUM_DIGITS-1} = residual v. No recentring.
- Output mapping: each negative digit becomes d+Q; non-negative digits pass through. Every output is in [0,Q).
- out_addr = out_cnt; out_cnt increments on each out_valid&out_ready. out_last = out_valid && out_cnt==FRAME_BEATS-1.
- Simultaneous last input accept and earlier-beat output accept in the same cycle are both honoured.

Optional Feature:
- Macro: DECOMP_ROUND_EN.
- Defined: stage 0 additionally rounds v to a multiple of 2^ROUND_BITS (localparam = DATA_W - BG_LOG*NUM_DIGITS, floored at 0), round half up. Digit 0 then skips the dropped bits: decomposition starts at bit ROUND_BITS. Latency unchanged.
- Undefined: exact decomposition as above; the rounding logic is absent.

Decomposition:
- Package fhew_pkg:
  - constants Q, RING_DEPTH, LANES, BG_LOG, NUM_DIGITS, FRAME_BEATS, ROUND_BITS.
  - typedefs coeff_t [DATA_W-1:0] and scoeff_t signed [DATA_W:0].
  - state enum.
- One sub-module: digit_extract_stage. Takes a signed residual and returns the centred digit plus the next residual. Instantiated NUM_DIGITS-1 times per lane.

Test Plan:
- Lane values {5, 300, Q-1, 256} -> out d0/d1/d2 = {5,0,0}, {Q-212,1,0}, {Q-1,0,0}, {Q-256,1,0}.
- x=(Q-1)/2=66060288 -> centre keeps positive; recomposed d0+d1*512+d2*512^2 (signed) == 66060288. x=(Q+1)/2 recomposes to (Q+1)/2-Q.
- Full frame of 256 beats, out_ready=1 -> first out_valid 4 cycles after first accept; out_addr 0..255; out_last on beat 255; done exactly one cycle after.
- out_ready toggling with pseudo-random 50% duty -> no beat lost or duplicated; data held stable while stalled; in_ready deasserts under backpressure.
- start pulsed during RUN -> ignored, counts unaffected. reset asserted at beat 100 -> all outputs 0 immediately, no done. A new start then runs a clean frame.
- Random 10k coefficients compared against a reference model in both DECOMP_ROUND_EN builds -> zero mismatches; all digits < Q.
